// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   IF-stage branch predictor. It combines a gshare pattern history table
//   (PHT) of 2-bit saturating counters, a direct-mapped branch target buffer
//   (BTB) and a speculative global history register (GHR).
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   fetch_valid     : fetch_pc is being issued this cycle
//   fetch_pc        : PC being fetched
//   pred_taken      : combinational taken prediction for fetch_pc
//   pred_target     : predicted target (zero on a BTB miss)
//   pred_ghr        : GHR snapshot used for this prediction, carried to EX
//   upd_valid       : EX resolved a conditional branch this cycle
//   upd_pc          : PC of the resolved branch
//   upd_taken       : resolved direction
//   upd_target      : resolved taken target
//   upd_ghr         : pred_ghr that travelled with the branch
//   upd_mispredict  : direction/target mismatch, qualified by upd_valid
module gshare_branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_valid,
  input  logic [31:0]         fetch_pc,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispredict
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  // 2-bit saturating counter step
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  logic [1:0]          r_pht        [ENTRIES];
  logic [ENTRIES-1:0]  r_btb_valid;
  logic [TAG_W-1:0]    r_btb_tag    [ENTRIES];
  logic [31:0]         r_btb_target [ENTRIES];
  logic [GHR_BITS-1:0] r_ghr;

  logic [IDX_BITS-1:0] w_fetch_bidx;
  logic [IDX_BITS-1:0] w_fetch_pidx;
  logic [TAG_W-1:0]    w_fetch_tag;
  logic                w_hit;
  logic [IDX_BITS-1:0] w_upd_bidx;
  logic [IDX_BITS-1:0] w_upd_pidx;
  logic [TAG_W-1:0]    w_upd_tag;
  logic                w_unused;

  // Instruction-alignment bits never take part in indexing.
  assign w_unused = &{1'b0, fetch_pc[1:0], upd_pc[1:0]};

  // Predict path: purely combinational, reads pre-update state (no bypass)
  assign w_fetch_bidx = fetch_pc[IDX_BITS+1:2];
  assign w_fetch_tag  = fetch_pc[31:IDX_BITS+2];
  assign w_fetch_pidx = w_fetch_bidx ^ IDX_BITS'(r_ghr);
  assign w_hit        = r_btb_valid[w_fetch_bidx] && (r_btb_tag[w_fetch_bidx] == w_fetch_tag);
  assign pred_taken   = w_hit && r_pht[w_fetch_pidx][1];
  assign pred_target  = w_hit ? r_btb_target[w_fetch_bidx] : 32'd0;
  assign pred_ghr     = r_ghr;

  assign w_upd_bidx = upd_pc[IDX_BITS+1:2];
  assign w_upd_tag  = upd_pc[31:IDX_BITS+2];
  assign w_upd_pidx = w_upd_bidx ^ IDX_BITS'(upd_ghr);

  // Update stage: counters, BTB valid bits and history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr       <= '0;
      r_btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_pht[i] <= 2'b01;
    end else begin
      if (upd_valid) begin
        r_pht[w_upd_pidx] <= ctr_next(r_pht[w_upd_pidx], upd_taken);
        if (upd_taken) r_btb_valid[w_upd_bidx] <= 1'b1;
      end
      // A mispredict restore flushes the younger fetch, so its shift is dropped.
      if (upd_valid && upd_mispredict)
        r_ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
      else if (fetch_valid && w_hit)
        r_ghr <= {r_ghr[GHR_BITS-2:0], pred_taken};
    end
  end

  // BTB payload carries no reset; valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      r_btb_tag[w_upd_bidx]    <= w_upd_tag;
      r_btb_target[w_upd_bidx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [5:0]  pred_ghr;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [5:0]  upd_ghr = '0;
  logic        upd_mispredict = 1'b0;

  gshare_branch_predictor #(.IDX_BITS(6), .GHR_BITS(6)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 64 counters as integers 0..3, BTB as plain arrays.
  int          m_pht [64];
  bit          m_bv  [64];
  int unsigned m_tag [64];
  int unsigned m_tgt [64];
  int unsigned m_ghr;

  function automatic void m_predict(input int unsigned pc, output bit hit,
                                    output bit taken, output int unsigned tgt);
    int unsigned b;
    b     = (pc >> 2) % 64;
    hit   = m_bv[b] && (m_tag[b] == (pc >> 8));
    taken = hit && (m_pht[b ^ m_ghr] >= 2);
    tgt   = hit ? m_tgt[b] : 0;
  endfunction

  always @(posedge clk) begin
    bit h, t;
    int unsigned tg, b, p;
    if (rst) begin
      m_ghr = 0;
      for (int i = 0; i < 64; i++) begin m_pht[i] = 1; m_bv[i] = 0; end
    end else begin
      m_predict(fetch_pc, h, t, tg);
      if (upd_valid) begin
        b = (upd_pc >> 2) % 64;
        p = b ^ upd_ghr;
        if (upd_taken) begin
          if (m_pht[p] < 3) m_pht[p] = m_pht[p] + 1;
          m_bv[b]  = 1;
          m_tag[b] = upd_pc >> 8;
          m_tgt[b] = upd_target;
        end else if (m_pht[p] > 0) m_pht[p] = m_pht[p] - 1;
      end
      if (upd_valid && upd_mispredict) m_ghr = ((upd_ghr * 2) + upd_taken) % 64;
      else if (fetch_valid && h)       m_ghr = ((m_ghr * 2) + t) % 64;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit h, t;
    int unsigned tg;
    if (chk_en) begin
      m_predict(fetch_pc, h, t, tg);
      chk("model_taken",  {31'd0, pred_taken}, {31'd0, t});
      chk("model_target", pred_target, tg);
      chk("model_ghr",    {26'd0, pred_ghr}, m_ghr);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    fetch_valid = 0; fetch_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_target = '0; upd_ghr = '0; upd_mispredict = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic [5:0] g, input logic mis);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_ghr = g; upd_mispredict = mis;
    step();
    upd_valid = 0; upd_mispredict = 0;
  endtask

  task automatic lit(input logic [31:0] pc, input string name, input logic tk,
                     input logic [31:0] tgt, input logic [5:0] g);
    fetch_pc = pc; #1;
    chk({name, "_taken"},  {31'd0, pred_taken}, {31'd0, tk});
    chk({name, "_target"}, pred_target, tgt);
    chk({name, "_ghr"},    {26'd0, pred_ghr}, {26'd0, g});
  endtask

  initial begin
    idle();
    do_reset();
    chk_en = 1;

    // Reset state
    lit(32'h60, "reset", 0, 0, 0);

    // First taken update allocates BTB[24] and moves PHT[24] to weakly taken
    upd(32'h60, 1, 32'h100, 0, 0);
    lit(32'h60, "first_upd", 1, 32'h100, 0);

    // Saturate at 11, one not-taken leaves 10 (still taken), another gives 01
    repeat (3) upd(32'h60, 1, 32'h100, 0, 0);
    upd(32'h60, 0, 0, 0, 0);
    lit(32'h60, "sat_hi_dec1", 1, 32'h100, 0);
    upd(32'h60, 0, 0, 0, 0);
    lit(32'h60, "sat_hi_dec2", 0, 32'h100, 0);

    // Lower saturation: far more not-taken than the counter range, then one taken
    do_reset();
    repeat (7) upd(32'h60, 0, 0, 0, 0);
    upd(32'h60, 1, 32'h100, 0, 0);
    lit(32'h60, "sat_lo", 0, 32'h100, 0);

    // Speculative history: train PHT at 24^0, 24^1, 24^3 so three taken hits follow
    do_reset();
    upd(32'h60, 1, 32'h100, 6'd0, 0);
    upd(32'h60, 1, 32'h100, 6'd1, 0);
    upd(32'h60, 1, 32'h100, 6'd3, 0);
    fetch_valid = 1;
    lit(32'h60, "spec0", 1, 32'h100, 6'd0);
    step();
    lit(32'h60, "spec1", 1, 32'h100, 6'd1);
    step();
    lit(32'h60, "spec2", 1, 32'h100, 6'd3);
    step();
    chk("spec_ghr3", {26'd0, pred_ghr}, 32'd7);
    // Restore wins over the same-cycle fetch shift
    upd(32'h60, 0, 0, 6'b000001, 1);
    fetch_valid = 0;
    chk("restore_ghr", {26'd0, pred_ghr}, 32'd2);

    // Alias: 0x160 evicts 0x60 from BTB slot 24
    do_reset();
    upd(32'h60, 1, 32'h100, 0, 0);
    upd(32'h160, 1, 32'h200, 0, 0);
    lit(32'h60,  "alias_miss", 0, 0, 0);
    lit(32'h160, "alias_hit",  1, 32'h200, 0);
    fetch_valid = 1; step(); fetch_valid = 0;
    chk("alias_ghr", {26'd0, pred_ghr}, 32'd1);

    // Reset during an update discards the update and clears all state
    rst = 1;
    upd(32'h60, 1, 32'h100, 0, 1);
    rst = 0;
    lit(32'h60,  "rst_upd_a", 0, 0, 0);
    lit(32'h160, "rst_upd_b", 0, 0, 0);

    // Randomized traffic over a small PC pool so hits, aliases and restores recur
    for (int n = 0; n < 2500; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      fetch_valid    = $urandom_range(0, 1);
      fetch_pc       = ($urandom_range(0, 1) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upd_valid      = ($urandom_range(0, 2) != 0);
      upd_pc         = ($urandom_range(0, 1) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upd_taken      = $urandom_range(0, 1);
      upd_target     = $urandom;
      upd_ghr        = 6'($urandom_range(0, 63));
      upd_mispredict = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 0;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
